// File: rtl/fifo_rdarbiter.sv
// Purpose : round-robin burst drain of CHANNELS_CNT FWFT channel FIFOs into one tagged stream.
// Latency : a pop in cycle N presents the word on o_valid/o_data in cycle N+1; 1 bubble per re-grant.
// Backpr. : single output register; while o_valid & ~i_ready the word holds and no channel is popped.
//
// Ports
//   clk, rst_n           clock (rising edge) and async active-low reset
//   i_en                 arbitration enable; dropping it ends the burst and parks the FSM in IDLE
//   i_rd_valid_channels  FWFT head-valid per channel
//   i_rd_data_channels   FWFT head data per channel, channel c at [c*CHANNEL_WIDTH +: CHANNEL_WIDTH]
//   o_rd_en_channels     pop strobe per channel, one-hot or zero
//   o_valid / i_ready    output handshake
//   o_data               output word
//   o_channel_id         channel the word was popped from
//   o_last               word was the BURST_LEN-th of its grant
//   o_busy               FSM is not in IDLE
module fifo_rdarbiter #(
  parameter int CHANNEL_WIDTH = 32,
  parameter int CHANNELS_CNT  = 5,
  parameter int BURST_LEN     = 16
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic                                    i_en,
  input  logic [CHANNELS_CNT-1:0]                 i_rd_valid_channels,
  input  logic [CHANNELS_CNT*CHANNEL_WIDTH-1:0]   i_rd_data_channels,
  output logic [CHANNELS_CNT-1:0]                 o_rd_en_channels,
  output logic                                    o_valid,
  input  logic                                    i_ready,
  output logic [CHANNEL_WIDTH-1:0]                o_data,
  output logic [$clog2(CHANNELS_CNT)-1:0]         o_channel_id,
  output logic                                    o_last,
  output logic                                    o_busy
);

  localparam int IDW = $clog2(CHANNELS_CNT);
  localparam int BCW = $clog2(BURST_LEN + 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ARB  = 2'd1;
  localparam logic [1:0] ST_XFER = 2'd2;

  localparam logic [IDW-1:0] LAST_CH    = IDW'(CHANNELS_CNT - 1);
  localparam logic [BCW-1:0] BURST_MAX  = BCW'(BURST_LEN);
  localparam logic [BCW-1:0] BURST_LAST = BCW'(BURST_LEN - 1);

  logic [1:0]               state;
  logic [1:0]               state_nxt;
  // rr_ptr doubles as the current grant: it is loaded with the winner in ARB
  // and stays put for the whole burst, so a separate grant register would
  // always hold the same value.
  logic [IDW-1:0]           rr_ptr;
  logic [BCW-1:0]           beat_cnt;

  logic                     arb_found;
  logic [IDW-1:0]           arb_pick;
  logic [IDW-1:0]           arb_cand;

  logic                     grant_vld;
  logic [CHANNEL_WIDTH-1:0] grant_dat;
  logic                     out_free;
  logic                     pop;
  logic                     burst_done;
  logic                     arb_take;

  // Round-robin search: walk rr_ptr+1, rr_ptr+2, ... with wrap, first valid
  // channel wins. Walking the candidate with an explicit wrap keeps the index
  // in range for non-power-of-two channel counts.
  always_comb begin
    arb_found = 1'b0;
    arb_pick  = rr_ptr;
    arb_cand  = rr_ptr;
    for (int i = 0; i < CHANNELS_CNT; i++) begin
      arb_cand = (arb_cand == LAST_CH) ? '0 : arb_cand + IDW'(1);
      if (!arb_found && i_rd_valid_channels[arb_cand]) begin
        arb_found = 1'b1;
        arb_pick  = arb_cand;
      end
    end
  end

  assign grant_vld = i_rd_valid_channels[rr_ptr];
  assign grant_dat = i_rd_data_channels[rr_ptr*CHANNEL_WIDTH +: CHANNEL_WIDTH];

  // Output register can take a word if it is empty or being drained this cycle.
  assign out_free = ~o_valid | i_ready;

  assign pop = (state == ST_XFER) & grant_vld & out_free & (beat_cnt < BURST_MAX);

  // Leave XFER on the cycle the final beat pops so that the only gap between
  // bursts is the single ARB cycle. The ==BURST_MAX term is a safety net.
  assign burst_done = (pop & (beat_cnt == BURST_LAST)) | (beat_cnt == BURST_MAX);

  assign arb_take = (state == ST_ARB) & i_en & arb_found;

  always_comb begin
    o_rd_en_channels = '0;
    if (pop) begin
      o_rd_en_channels[rr_ptr] = 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (i_en) begin
          state_nxt = ST_ARB;
        end
      end
      ST_ARB: begin
        if (!i_en) begin
          state_nxt = ST_IDLE;
        end else if (arb_found) begin
          state_nxt = ST_XFER;
        end
      end
      ST_XFER: begin
        // Disable goes through ARB, which then drops to IDLE next cycle.
        if (!i_en || !grant_vld || burst_done) begin
          state_nxt = ST_ARB;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      rr_ptr   <= LAST_CH;
      beat_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (arb_take) begin
        rr_ptr   <= arb_pick;
        beat_cnt <= '0;
      end else if (pop) begin
        beat_cnt <= beat_cnt + BCW'(1);
      end
    end
  end

  // Single-stage output register. A pop always refills it; otherwise an
  // accepted word empties it and an unaccepted word is held unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_valid      <= 1'b0;
      o_data       <= '0;
      o_channel_id <= '0;
      o_last       <= 1'b0;
    end else begin
      if (pop) begin
        o_valid      <= 1'b1;
        o_data       <= grant_dat;
        o_channel_id <= rr_ptr;
        o_last       <= (beat_cnt == BURST_LAST);
      end else if (i_ready) begin
        o_valid      <= 1'b0;
      end
    end
  end

  assign o_busy = (state != ST_IDLE);

endmodule

// File: tb/tb_fifo_rdarbiter.sv
// Purpose : directed bench for fifo_rdarbiter with FWFT channel models and an output scoreboard.
// Latency : inputs change 1 time unit after the rising edge; DUT outputs are sampled on the falling edge.
// Backpr. : i_ready is driven per test, including a stall pattern during a burst.
module tb_fifo_rdarbiter;

  localparam int W   = 32;
  localparam int CH  = 5;
  localparam int BL  = 16;
  localparam int IDW = 3;

  logic            clk;
  logic            rst_n;
  logic            i_en;
  logic [CH-1:0]   i_rd_valid_channels;
  logic [CH*W-1:0] i_rd_data_channels;
  logic [CH-1:0]   o_rd_en_channels;
  logic            o_valid;
  logic            i_ready;
  logic [W-1:0]    o_data;
  logic [IDW-1:0]  o_channel_id;
  logic            o_last;
  logic            o_busy;

  fifo_rdarbiter #(
    .CHANNEL_WIDTH (W),
    .CHANNELS_CNT  (CH),
    .BURST_LEN     (BL)
  ) u_dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .i_en                (i_en),
    .i_rd_valid_channels (i_rd_valid_channels),
    .i_rd_data_channels  (i_rd_data_channels),
    .o_rd_en_channels    (o_rd_en_channels),
    .o_valid             (o_valid),
    .i_ready             (i_ready),
    .o_data              (o_data),
    .o_channel_id        (o_channel_id),
    .o_last              (o_last),
    .o_busy              (o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic           last;
    logic [IDW-1:0] id;
    logic [W-1:0]   dat;
  } exp_t;

  logic [W-1:0] mem [CH][64];
  int           ch_wr [CH];
  int           ch_rd [CH];
  int           pops  [CH];
  exp_t         exp_q [$];

  int           n_checks;
  int           n_err;
  int           cyc;
  int           first_v;
  int           last_v;
  logic [CH-1:0] snap_rd;
  logic         prev_pop;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] req);
    n_checks++;
    if (obs !== req) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, req, cyc);
    end
  endtask

  task automatic drive_inputs();
    for (int c = 0; c < CH; c++) begin
      i_rd_valid_channels[c]        = (ch_rd[c] < ch_wr[c]);
      i_rd_data_channels[c*W +: W]  = mem[c][ch_rd[c] % 64];
    end
  endtask

  task automatic load(input int c, input int n, input int base);
    for (int i = 0; i < n; i++) begin
      mem[c][ch_wr[c]] = W'(base + i);
      ch_wr[c]++;
    end
    drive_inputs();
  endtask

  // Expected words c:base..base+n-1, o_last only on the final one if a full burst.
  task automatic exp_burst(input int c, input int base, input int n, input bit last_at_end);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.dat  = W'(base + i);
      e.id   = IDW'(c);
      e.last = last_at_end && (i == n - 1);
      exp_q.push_back(e);
    end
  endtask

  // One clock: sample/check on the falling edge, advance FIFO models after the rising edge.
  task automatic cycle();
    exp_t e;
    @(negedge clk);
    snap_rd = o_rd_en_channels;
    if (prev_pop) check("pop_latency", o_valid, 1);
    if (snap_rd != '0) begin
      check("rd_en_onehot", $onehot(snap_rd), 1);
      check("pop_nonempty", snap_rd & ~i_rd_valid_channels, 0);
    end
    if (o_valid && !i_ready) check("stall_nopop", snap_rd, 0);
    if (o_valid) begin
      if (first_v < 0) first_v = cyc;
      last_v = cyc;
      if (exp_q.size() == 0) begin
        check("extra_word", o_valid, 0);
      end else begin
        e = exp_q[0];
        check("word", {o_last, o_channel_id, o_data}, e);
        if (i_ready) void'(exp_q.pop_front());
      end
    end
    prev_pop = |snap_rd;
    @(posedge clk);
    #1;
    cyc++;
    for (int c = 0; c < CH; c++) begin
      if (snap_rd[c] && ch_rd[c] < ch_wr[c]) begin
        ch_rd[c]++;
        pops[c]++;
      end
    end
    drive_inputs();
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      cycle();
      n++;
    end
    check("drain_left", exp_q.size(), 0);
    repeat (3) cycle();
  endtask

  // Assert reset, empty all channel models and the scoreboard; reset stays asserted.
  task automatic do_reset();
    rst_n    = 1'b0;
    i_en     = 1'b0;
    prev_pop = 1'b0;
    first_v  = -1;
    last_v   = -1;
    exp_q.delete();
    for (int c = 0; c < CH; c++) begin
      ch_wr[c] = 0;
      ch_rd[c] = 0;
      pops[c]  = 0;
    end
    drive_inputs();
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic release_and_enable();
    rst_n = 1'b1;
    i_en  = 1'b1;
  endtask

  initial begin
    int n;
    int before0;
    int before1;
    logic [3:0] pat;
    n_checks = 0;
    n_err    = 0;
    cyc      = 0;
    i_ready  = 1'b1;
    i_rd_valid_channels = '0;
    i_rd_data_channels  = '0;

    // Reset state
    do_reset();
    check("rst_valid", o_valid, 0);
    check("rst_rd_en", o_rd_en_channels, 0);
    check("rst_busy",  o_busy, 0);
    check("rst_data",  o_data, 0);
    check("rst_id",    o_channel_id, 0);
    check("rst_last",  o_last, 0);

    // 1: short burst from ch2, ends on drain, FSM back in ARB
    load(2, 3, 1);
    exp_burst(2, 1, 3, 1'b0);
    release_and_enable();
    drain(50);
    check("t1_busy", o_busy, 1);
    check("t1_valid", o_valid, 0);

    // 2: all channels 20 words -> 16-word bursts 0..4, then 4-word tails 0..4
    do_reset();
    for (int c = 0; c < CH; c++) load(c, 20, c * 256);
    for (int c = 0; c < CH; c++) exp_burst(c, c * 256, 16, 1'b1);
    for (int c = 0; c < CH; c++) exp_burst(c, c * 256 + 16, 4, 1'b0);
    release_and_enable();
    drain(400);

    // 3: i_ready stall pattern 1,0,0,1 during a burst
    do_reset();
    load(1, 10, 256);
    exp_burst(1, 256, 10, 1'b0);
    release_and_enable();
    pat = 4'b1001;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      i_ready = pat[n % 4];
      cycle();
      n++;
    end
    check("t3_left", exp_q.size(), 0);
    i_ready = 1'b1;
    repeat (3) cycle();

    // 4: only ch4, 40 words -> 16,16,8 with one bubble between bursts
    do_reset();
    load(4, 40, 1024);
    exp_burst(4, 1024, 16, 1'b1);
    exp_burst(4, 1040, 16, 1'b1);
    exp_burst(4, 1056, 8, 1'b0);
    release_and_enable();
    drain(200);
    check("t4_span", last_v - first_v, 41);

    // 5: drop i_en after beat 5 of ch0, then resume with ch1
    do_reset();
    load(0, 20, 0);
    load(1, 20, 256);
    exp_burst(0, 0, 6, 1'b0);
    release_and_enable();
    n = 0;
    while (pops[0] < 5 && n < 100) begin
      cycle();
      n++;
    end
    check("t5_reach", pops[0], 5);
    i_en = 1'b0;
    before0 = pops[0];
    before1 = pops[1];
    repeat (4) cycle();
    check("t5_pops_ch0", pops[0] - before0, 1);
    check("t5_pops_ch1", pops[1] - before1, 0);
    check("t5_idle", o_busy, 0);
    check("t5_left", exp_q.size(), 0);
    exp_burst(1, 256, 16, 1'b1);
    exp_burst(0, 6, 14, 1'b0);
    exp_burst(1, 256 + 16, 4, 1'b0);
    i_en = 1'b1;
    drain(200);

    // 6: reset pulse mid-burst, ch0 first after release
    do_reset();
    load(1, 10, 256);
    load(3, 10, 768);
    exp_burst(1, 256, 10, 1'b0);
    release_and_enable();
    n = 0;
    while (pops[1] < 3 && n < 100) begin
      cycle();
      n++;
    end
    check("t6_reach", pops[1], 3);
    rst_n    = 1'b0;
    prev_pop = 1'b0;
    #1;
    check("t6_rst_valid", o_valid, 0);
    check("t6_rst_rd_en", o_rd_en_channels, 0);
    check("t6_rst_busy",  o_busy, 0);
    exp_q.delete();
    load(0, 3, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_burst(0, 0, 3, 1'b0);
    exp_burst(1, 256 + 3, 7, 1'b0);
    exp_burst(3, 768, 10, 1'b0);
    drain(200);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
